// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with standard or first-word-fall-through read port
module sync_fifo #(
    parameter int Data_width = 8,
    parameter int Addr_width = 5,
    parameter int FWFT       = 0,
    parameter int AF_level   = (1 << Addr_width) - 4,
    parameter int AE_level   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Wr_enable,
    input  logic [Data_width-1:0] data_in,
    input  logic                  Read_enable,
    input  logic                  err_clr,
    output logic [Data_width-1:0] data_out,
    output logic                  data_valid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_full,
    output logic                  Almost_empty,
    output logic [Addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << Addr_width;
    localparam logic [Addr_width:0] AF_CNT = AF_level[Addr_width:0];
    localparam logic [Addr_width:0] AE_CNT = AE_level[Addr_width:0];

    logic [Data_width-1:0] mem [DEPTH];

    logic [Addr_width:0] wr_ptr_q, wr_ptr_d;
    logic [Addr_width:0] rd_ptr_q, rd_ptr_d;
    logic [Addr_width:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                wr_accept;
    logic                rd_accept;

    assign wr_accept = Wr_enable && !full_q;
    assign rd_accept = Read_enable && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
        // Equal low bits with differing MSBs means the writer lapped the reader
        full_d   = (wr_ptr_d[Addr_width] != rd_ptr_d[Addr_width]) &&
                   (wr_ptr_d[Addr_width-1:0] == rd_ptr_d[Addr_width-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= AF_CNT);
        aempty_d = (count_d <= AE_CNT);
        ovf_d    = (Wr_enable && full_q) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
        unf_d    = (Read_enable && empty_q) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; reset only discards it by clearing the pointers
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[Addr_width-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = empty_q ? '0 : mem[rd_ptr_q[Addr_width-1:0]];
            assign data_valid = !empty_q;
        end else begin : g_std
            logic [Data_width-1:0] dout_q, dout_d;
            logic                  dv_q, dv_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_accept) begin
                    dout_d = mem[rd_ptr_q[Addr_width-1:0]];
                end
                dv_d = rd_accept;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dv_q   <= dv_d;
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end
    endgenerate

    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_full  = afull_q;
    assign Almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo in standard and FWFT modes
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout0, dout1;
    logic       dv0, dv1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [5:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;

    int         mcount = 0;
    logic       movf = 1'b0;
    logic       munf = 1'b0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo #(.Data_width(8), .Addr_width(5), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .Wr_enable(wr), .data_in(din), .Read_enable(rd),
        .err_clr(clr), .data_out(dout0), .data_valid(dv0), .Full(full0),
        .Empty(empty0), .Almost_full(af0), .Almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo #(.Data_width(8), .Addr_width(5), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .Wr_enable(wr), .data_in(din), .Read_enable(rd),
        .err_clr(clr), .data_out(dout1), .data_valid(dv1), .Full(full1),
        .Empty(empty1), .Almost_full(af1), .Almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         e_count;
        logic       e_empty;
        logic       e_unf;
        logic       e_dv;
        logic       chk_dout;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cnt0"}, int'(cnt0), 0);
        chk({tag, "_empty0"}, int'(empty0), 1);
        chk({tag, "_full0"}, int'(full0), 0);
        chk({tag, "_ae0"}, int'(ae0), 1);
        chk({tag, "_af0"}, int'(af0), 0);
        chk({tag, "_dout0"}, int'(dout0), 0);
        chk({tag, "_dv0"}, int'(dv0), 0);
        chk({tag, "_ovf0"}, int'(ovf0), 0);
        chk({tag, "_unf0"}, int'(unf0), 0);
        chk({tag, "_cnt1"}, int'(cnt1), 0);
        chk({tag, "_dv1"}, int'(dv1), 0);
        chk({tag, "_dout1"}, int'(dout1), 0);
    endtask

    // One clock of stimulus checked against the queue model
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic       wacc, racc;
        logic [7:0] exp_d;
        exp_d = 8'h00;
        if (mcount > 0) begin
            chk("fwft_head", int'(dout1), int'(sb[0]));
            chk("fwft_dv", int'(dv1), 1);
        end
        wr = w; rd = r; clr = c; din = d;
        wacc = w && (mcount < 32);
        racc = r && (mcount > 0);
        movf = (w && mcount == 32) ? 1'b1 : (c ? 1'b0 : movf);
        munf = (r && mcount == 0) ? 1'b1 : (c ? 1'b0 : munf);
        if (racc) exp_d = sb.pop_front();
        if (wacc) sb.push_back(d);
        mcount = mcount + int'(wacc) - int'(racc);
        step();
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        chk("count", int'(cnt0), mcount);
        chk("count_fwft", int'(cnt1), mcount);
        chk("empty", int'(empty0), int'(mcount == 0));
        chk("full", int'(full0), int'(mcount == 32));
        chk("almost_full", int'(af0), int'(mcount >= 28));
        chk("almost_empty", int'(ae0), int'(mcount <= 4));
        chk("overflow", int'(ovf0), int'(movf));
        chk("underflow", int'(unf0), int'(munf));
        chk("data_valid", int'(dv0), int'(racc));
        if (racc) chk("data_out", int'(dout0), int'(exp_d));
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h4D, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'hFF, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4D};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};

        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wr = vecs[i].wr; rd = vecs[i].rd; clr = vecs[i].clr; din = vecs[i].din;
            step();
            chk($sformatf("vec%0d_count", i), int'(cnt0), vecs[i].e_count);
            chk($sformatf("vec%0d_empty", i), int'(empty0), int'(vecs[i].e_empty));
            chk($sformatf("vec%0d_unf", i), int'(unf0), int'(vecs[i].e_unf));
            chk($sformatf("vec%0d_dv", i), int'(dv0), int'(vecs[i].e_dv));
            if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), int'(dout0), int'(vecs[i].e_dout));
        end
        wr = 1'b0; rd = 1'b0; clr = 1'b0;

        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h4D + i));
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ovf_set", int'(ovf0), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
        chk("rw_hold_count", int'(cnt0), 16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);

        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("fwft_a5_dout", int'(dout1), 8'hA5);
        chk("fwft_a5_dv", int'(dv1), 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_after_read_empty", int'(empty1), 1);
        chk("fwft_after_read_dv", int'(dv1), 0);

        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pre_reset_count", int'(cnt0), 10);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        mcount = 0; movf = 1'b0; munf = 1'b0;
        step();
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h5A);
        chk("post_reset_write", int'(cnt0), 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter Data_width, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter Addr_width, default 5, giving depth DEPTH = 2^Addr_width (32).
REQ-003 The block SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 The block SHALL have parameter AF_level, default DEPTH-4, giving the almost-full threshold.
REQ-005 The block SHALL have parameter AE_level, default 4, giving the almost-empty threshold.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port Wr_enable, input, 1 bit: write request.
REQ-009 The block SHALL have port data_in, input, Data_width bits: write data.
REQ-010 The block SHALL have port Read_enable, input, 1 bit: read request.
REQ-011 The block SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-012 The block SHALL have port data_out, output, Data_width bits: read data.
REQ-013 The block SHALL have port data_valid, output, 1 bit: data_out holds valid data.
REQ-014 The block SHALL have ports Full, Empty, Almost_full and Almost_empty, each output, 1 bit: status flags.
REQ-015 The block SHALL have port count, output, Addr_width+1 bits: occupancy, range 0..DEPTH.
REQ-016 The block SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-017 The block SHALL accept a write when Wr_enable=1 and Full=0, storing data_in at the write pointer and incrementing it modulo DEPTH.
REQ-018 The block SHALL accept a read when Read_enable=1 and Empty=0, incrementing the read pointer modulo DEPTH.
REQ-019 Simultaneous accepted read and write SHALL leave count unchanged; Full blocks the write even if a read is accepted in the same cycle.
REQ-020 On Empty, Read_enable with Wr_enable SHALL accept only the write; the read is rejected.
REQ-021 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged otherwise; it never exceeds DEPTH and never goes below 0.
REQ-022 Full=(count==DEPTH), Empty=(count==0), Almost_full=(count>=AF_level) and Almost_empty=(count<=AE_level) SHALL all be registered and consistent with count in the same cycle.
REQ-023 Pointers SHALL be Addr_width+1 bits wide so that full and empty are distinguished by the MSB after wrap-around.
REQ-024 With FWFT=0, data_out SHALL be registered, load the head word on the edge of an accepted read (1-cycle latency), and hold its value otherwise.
REQ-025 With FWFT=0, data_valid SHALL be 1 for exactly the cycle after each accepted read, and 0 otherwise.
REQ-026 With FWFT=1, data_out SHALL present the head word whenever Empty=0, with data_valid equal to !Empty; an accepted read advances to the next word.
REQ-027 With FWFT=1, a word written into an empty FIFO SHALL appear on data_out the cycle after the write.
REQ-028 overflow SHALL set on the edge where Wr_enable=1 and Full=1, and underflow SHALL set on the edge where Read_enable=1 and Empty=1.
REQ-029 Both error flags SHALL stay set until err_clr=1; if err_clr and a new error event occur in the same cycle, the set wins.
REQ-030 Rejected operations SHALL NOT change memory contents, pointers or count.

Reset
REQ-031 While rst=0, the block SHALL clear both pointers and count to 0 and drive Empty=1, Almost_empty=1, Full=0, Almost_full=0, data_out=0, data_valid=0, overflow=0 and underflow=0.
REQ-032 Assertion of rst mid-operation SHALL discard all stored words immediately; memory contents need not be cleared.
REQ-033 After rst rises, the first edge SHALL accept operations normally.

Verification
REQ-034 Bench: reset, then Read_enable=1 for 1 cycle -> Empty=1, underflow=1, count=0, data_valid=0; err_clr pulse -> underflow=0.
REQ-035 Bench (FWFT=0): write 0x4D, then write 0xFF, then two reads -> data_out=0x4D then 0xFF, each one cycle after its read, with data_valid pulsing; Empty=1 at the end.
REQ-036 Bench: 32 writes of 0x4D+i -> Full=1, count=32, Almost_full set at count 28; a 33rd write -> overflow=1 and contents unchanged; 32 reads return 0x4D..0x6C in order.
REQ-037 Bench: at count=16, hold Wr_enable=1 and Read_enable=1 for 10 cycles -> count stays 16 and data order is preserved across pointer wrap.
REQ-038 Bench (FWFT=1): write 0xA5 to an empty FIFO -> data_out=0xA5 and data_valid=1 the next cycle, before any read; one read -> Empty=1.
REQ-039 Bench: drop rst to 0 mid-burst at count=10 -> all outputs take their REQ-031 values asynchronously, without waiting for a clock edge.
